hic_q13: RTL and testbench
==========================

// Module: hic_q13
// PURPOSE
//   Cascadable 8-bit loadable counter cell. One slice of a chained counter:
//   - a 2-bit mode selects hold, load, count or clear;
//   - carry-in/carry-out ripple the count enable between slices;
//   - the registered mode is forwarded so the next slice can be pipelined.
//   Sits in the datapath wherever a multi-byte counter is built from slices.
// PARAMETERS
//   WIDTH  8  data width of pin/fout (the bench uses only 8)
// PORTS
//   clk   input   1      rising-edge clock, sole clock domain
//   rst   input   1      synchronous reset, active-high, highest priority
//   cin   input   1      carry/count enable from the previous slice (1 for the LSB slice)
//   pin   input   WIDTH  parallel load value
//   m     input   2      mode select
//   cout  output  1      carry to the next slice (combinational)
//   fout  output  WIDTH  counter register value
//   mo    output  2      registered copy of m, for the next slice
// BEHAVIOUR
//   Clock and reset
//   - One clock (clk).
//   - Reset (rst) is synchronous and active-high.
//   - rst=1 at a rising edge: fout<=0 and mo<=0. It overrides every mode.
//   Mode encoding (sampled at the rising edge)
//   - 2'b00 HOLD:  fout unchanged.
//   - 2'b01 LOAD:  fout<=pin.
//   - 2'b10 COUNT: if cin=1 then fout<=fout+1 (wraps modulo 2^WIDTH); if cin=0, hold.
//   - 2'b11 CLEAR: fout<=0, independent of cin.
//   Mode forwarding
//   - mo<=m on every edge where rst=0. Latency is 1 clock.
//   Carry out
//   - cout = cin & (m==2'b10) & (fout=={WIDTH{1'b1}}).
//   - It is combinational from the current inputs and state, with no register.
//   - During rst, cout still follows this equation. Only state is reset.
//   Boundaries
//   - COUNT at 8'hFF with cin=1: fout wraps to 0x00, and cout is 1 in the cycle before that edge.
//   - LOAD of 0xFF does not assert cout. cout is only ever 1 in COUNT mode.
//   - A mode change takes effect at the next edge. There is no transient counting.
//   - Before the first reset or clear, fout is undefined (X). The bench must clear or reset first.
//   - No other outputs exist. fout is directly the register, with no output muxing.
// STRUCTURE
//   - Shared package hic_pkg holds:
//     - localparams MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_COUNT=2'b10, MODE_CLEAR=2'b11;
//     - a typedef for the mode (logic [1:0]).
//   - Optional sub-module hic_q13_inc: a WIDTH-bit incrementer (a + ci -> sum, co).
//     Its co feeds cout gating. Everything else is one always block plus assigns.
// TESTING (clk period 1000 ns, inputs changed mid-low phase)
//   1. m=3, cin=1, pin=10 for 1 edge -> fout=0x00, mo=3, cout=0.
//   2. m=1, pin=10 for 2 edges -> fout=0x0A both cycles, mo=1.
//   3. m=2, cin=1 for 2 edges -> fout=0x0B then 0x0C, mo=2, cout=0.
//      Then m=0 -> fout stays 0x0C, mo=0.
//   4. Load 0xFE, then m=2, cin=1 -> fout=0xFF with cout=1.
//      Next edge: fout=0x00 and cout=0.
//      With cin=0 at 0xFF: fout holds and cout=0.
//   5. Reset mid-count: m=2, cin=1, rst=1 at an edge -> fout=0x00, mo=0.
//      Release rst -> counting resumes 0x01, 0x02.
//   6. Chain two slices: hi.cin=lo.cout, hi.m=lo.m.
//      Load lo=0xFF, hi=0x00, count -> after 1 edge lo=0x00, hi=0x01.

Source files
------------

// File: rtl/hic_pkg.sv
// Shared definitions for the hic counter slice family: mode encodings and
// the mode type used on the m/mo ports.
`timescale 1ns/1ps

package hic_pkg;

  typedef logic [1:0] modeT;

  localparam modeT MODE_HOLD  = 2'b00;
  localparam modeT MODE_LOAD  = 2'b01;
  localparam modeT MODE_COUNT = 2'b10;
  localparam modeT MODE_CLEAR = 2'b11;

endpackage

// File: rtl/hic_q13_inc.sv
// WIDTH-bit incrementer: sum = a + ci, co set when the add overflows.
// The carry out only rises when a is all ones and ci is set, which is exactly
// the condition the slice needs to ripple its count enable onward.
`timescale 1ns/1ps

module hic_q13_inc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] w_total;

  assign w_total = {1'b0, a} + {{WIDTH{1'b0}}, ci};
  assign sum     = w_total[WIDTH-1:0];
  assign co      = w_total[WIDTH];

endmodule

// File: rtl/hic_q13.sv
// One cascadable slice of a multi-byte loadable counter. The mode selects
// hold/load/count/clear, cin/cout ripple the count enable between slices and
// mo hands the registered mode to the next slice for pipelined chains.
`timescale 1ns/1ps

module hic_q13
  import hic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [WIDTH-1:0] pin,
  input  modeT             m,
  output logic             cout,
  output logic [WIDTH-1:0] fout,
  output modeT             mo
);

  logic [WIDTH-1:0] r_fout;
  modeT             r_mo;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;

  // The incrementer is fed cin directly, so with cin=0 its sum equals the
  // current value and COUNT degenerates into a hold without extra muxing.
  hic_q13_inc #(
    .WIDTH (WIDTH)
  ) u_inc (
    .a   (r_fout),
    .ci  (cin),
    .sum (w_sum),
    .co  (w_co)
  );

  // Counter register and forwarded mode; reset wins over every mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fout <= '0;
      r_mo   <= MODE_HOLD;
    end else begin
      r_mo <= m;
      case (m)
        MODE_LOAD:  r_fout <= pin;
        MODE_COUNT: r_fout <= w_sum;
        MODE_CLEAR: r_fout <= '0;
        default:    r_fout <= r_fout;
      endcase
    end
  end

  // Carry is purely combinational and is not masked by reset, so a chain
  // still sees the ripple condition while its state is being cleared.
  assign cout = w_co & (m == MODE_COUNT);
  assign fout = r_fout;
  assign mo   = r_mo;

endmodule

// File: tb/tb_hic_q13.sv
// Bench for hic_q13: two slices chained into a 16-bit counter, checked
// against a 16-bit arithmetic model through an expectation queue.
`timescale 1ns/1ps

module tb_hic_q13;
  import hic_pkg::*;

  typedef struct {
    bit         checkCout;
    bit         checkValue;
    logic       coutLo;
    logic       coutHi;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [1:0] mo;
  } expT;

  logic       clk = 1'b0;
  logic       rst;
  logic       cin;
  logic [7:0] pinLo;
  logic [7:0] pinHi;
  modeT       m;
  logic       coutLo, coutHi;
  logic [7:0] foutLo, foutHi;
  modeT       moLo, moHi;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  int unsigned modelValue = 0;
  bit          modelKnown = 0;
  logic [1:0]  modelMo    = 2'b00;

  // 1000 ns clock period
  always #500 clk = ~clk;

  hic_q13 #(.WIDTH(8)) u_lo (
    .clk  (clk),
    .rst  (rst),
    .cin  (cin),
    .pin  (pinLo),
    .m    (m),
    .cout (coutLo),
    .fout (foutLo),
    .mo   (moLo)
  );

  hic_q13 #(.WIDTH(8)) u_hi (
    .clk  (clk),
    .rst  (rst),
    .cin  (coutLo),
    .pin  (pinHi),
    .m    (m),
    .cout (coutHi),
    .fout (foutHi),
    .mo   (moHi)
  );

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs mid-low phase and queue the model's prediction
  // for carry (before the edge) and register state (after the edge).
  task automatic applyStimulus(input bit r, input logic [1:0] mode, input bit c,
                               input logic [7:0] lo, input logic [7:0] hi);
    expT e;
    @(negedge clk);
    #250;
    rst   = r;
    m     = mode;
    cin   = c;
    pinLo = lo;
    pinHi = hi;

    e.checkCout = modelKnown;
    e.coutLo = c && (mode == 2'b10) && ((modelValue % 256) == 255);
    e.coutHi = c && (mode == 2'b10) && (modelValue == 65535);

    if (r) begin
      modelValue = 0;
      modelKnown = 1;
      modelMo    = 2'b00;
    end else begin
      modelMo = mode;
      if (mode == 2'b01) begin
        modelValue = hi * 256 + lo;
        modelKnown = 1;
      end else if (mode == 2'b10) begin
        if (c) modelValue = (modelValue + 1) % 65536;
      end else if (mode == 2'b11) begin
        modelValue = 0;
        modelKnown = 1;
      end
    end

    e.checkValue = modelKnown;
    e.lo = 8'(modelValue % 256);
    e.hi = 8'(modelValue / 256);
    e.mo = modelMo;
    expQ.push_back(e);
  endtask

  // Monitor: sample carry just before each edge, state just after it.
  initial begin
    expT  e;
    logic sLo, sHi;
    forever begin
      @(negedge clk);
      #400;
      sLo = coutLo;
      sHi = coutHi;
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.checkCout) begin
          checkOutput("coutLo", {7'b0, sLo}, {7'b0, e.coutLo});
          checkOutput("coutHi", {7'b0, sHi}, {7'b0, e.coutHi});
        end
        if (e.checkValue) begin
          checkOutput("foutLo", foutLo, e.lo);
          checkOutput("foutHi", foutHi, e.hi);
        end
        checkOutput("moLo", {6'b0, moLo}, {6'b0, e.mo});
        checkOutput("moHi", {6'b0, moHi}, {6'b0, e.mo});
      end
    end
  end

  // Directed scenarios first, then randomized traffic biased toward wraps.
  initial begin
    int  waitCycles;
    logic [7:0] rLo, rHi;
    rst = 1'b1; m = MODE_HOLD; cin = 1'b0; pinLo = 8'h00; pinHi = 8'h00;

    applyStimulus(1, MODE_HOLD, 0, 8'h00, 8'h00);
    applyStimulus(0, MODE_CLEAR, 1, 8'h0A, 8'h00);
    applyStimulus(0, MODE_LOAD, 0, 8'h0A, 8'h00);
    applyStimulus(0, MODE_LOAD, 0, 8'h0A, 8'h00);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_HOLD, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_LOAD, 0, 8'hFE, 8'h00);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_LOAD, 0, 8'hFF, 8'h00);
    applyStimulus(0, MODE_COUNT, 0, 8'h00, 8'h00);
    applyStimulus(0, MODE_LOAD, 1, 8'hFF, 8'hFF);
    applyStimulus(0, MODE_LOAD, 1, 8'hFF, 8'hFF);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(1, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);
    applyStimulus(0, MODE_COUNT, 1, 8'h00, 8'h00);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rLo = 8'hFF;
        1: rLo = 8'hFE;
        default: rLo = 8'($urandom);
      endcase
      rHi = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      applyStimulus(($urandom_range(0, 31) == 0), 2'($urandom),
                    ($urandom_range(0, 3) != 0), rLo, rHi);
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    @(posedge clk);
    #10;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
